// File: rtl/op_sequencer.sv
// op_sequencer: host-side initiator for the matrix controller.
// Expands LOAD / MULT / READ commands into timed 32-bit operation words,
// gates the controller enable while load data is missing, and captures
// serially read words into a single-cycle rd_valid/rd_data stream.
// Optional macro OP_SEQUENCER_IDLE_GAP_EN: when defined, one forced idle
// cycle follows every LOAD, MULT and READ/DRAIN; when undefined, the idle
// cycle is inserted only between consecutive MULT commands.
module op_sequencer #(
   parameter int WORDS       = 64,
   parameter int MULT_CYCLES = 600,
   parameter int READ_LAT    = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_kind,
   input  logic [23:0] cmd_args,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [31:0] wr_data,
   output logic        rd_valid,
   output logic [31:0] rd_data,
   output logic        busy,
   output logic        ctrl_enable,
   output logic [31:0] ctrl_operation,
   output logic [31:0] ctrl_in_data,
   input  logic [31:0] ctrl_out_data
);

   localparam int CNT_MAX = (WORDS > MULT_CYCLES) ? WORDS : MULT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS - 1);
   localparam logic [CNT_W-1:0] LAST_MULT = CNT_W'(MULT_CYCLES - 1);

   localparam logic [1:0] K_NOP  = 2'd0;
   localparam logic [1:0] K_MULT = 2'd1;
   localparam logic [1:0] K_LOAD = 2'd2;
   localparam logic [1:0] K_READ = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MULT,
      S_READ,
      S_DRAIN,
      S_GAP
   } state_t;

`ifdef OP_SEQUENCER_IDLE_GAP_EN
   // Every command ends in the gap; the gap always returns to IDLE.
   localparam state_t S_DONE     = S_GAP;
   localparam state_t S_GAP_EXIT = S_IDLE;
`else
   // Commands end in IDLE; the gap only ever precedes a repeated MULT.
   localparam state_t S_DONE     = S_IDLE;
   localparam state_t S_GAP_EXIT = S_MULT;
`endif

   state_t              r_state;
   state_t              w_next;
   logic [1:0]          r_kind;
   logic [23:0]         r_args;
   logic [CNT_W-1:0]    r_cnt;
   logic [READ_LAT-1:0] r_pipe;
   logic                r_rd_valid;
   logic [31:0]         r_rd_data;
   logic                w_accept;
   logic [31:0]         w_op_word;

   assign w_accept  = cmd_valid && (r_state == S_IDLE);
   assign w_op_word = {4'b0000, r_args, 2'b00, r_kind};

`ifndef OP_SEQUENCER_IDLE_GAP_EN
   logic r_prev_mult;

   // Remember whether the last real (non-NOP) command was a MULT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev_mult <= 1'b0;
      end else if (w_accept && (cmd_kind != K_NOP)) begin
         r_prev_mult <= (cmd_kind == K_MULT);
      end
   end
`endif

   // Next-state selection.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned and no latch is inferred.
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (cmd_kind)
`ifdef OP_SEQUENCER_IDLE_GAP_EN
                  K_MULT:  w_next = S_MULT;
`else
                  K_MULT:  w_next = r_prev_mult ? S_GAP : S_MULT;
`endif
                  K_LOAD:  w_next = S_LOAD;
                  K_READ:  w_next = S_READ;
                  default: w_next = S_IDLE;
               endcase
            end
         end
         S_LOAD:  if (wr_valid && (r_cnt == LAST_WORD)) w_next = S_DONE;
         S_MULT:  if (r_cnt == LAST_MULT) w_next = S_DONE;
         S_READ:  if (r_cnt == LAST_WORD) w_next = S_DRAIN;
         S_DRAIN: if (r_pipe == '0) w_next = S_DONE;
         S_GAP:   w_next = S_GAP_EXIT;
         default: w_next = S_IDLE;
      endcase
   end

   // Per-state outputs towards host and controller.
   always_comb begin
      cmd_ready      = 1'b0;
      busy           = 1'b1;
      wr_ready       = 1'b0;
      ctrl_enable    = 1'b1;
      ctrl_in_data   = '0;
      ctrl_operation = '0;
      unique case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
         end
         S_LOAD: begin
            wr_ready       = 1'b1;
            ctrl_enable    = wr_valid;
            ctrl_in_data   = wr_data;
            ctrl_operation = w_op_word;
         end
         S_MULT, S_READ: ctrl_operation = w_op_word;
         default: ;
      endcase
   end

   // State register, command latch and per-command cycle/word counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_kind  <= K_NOP;
         r_args  <= '0;
         r_cnt   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_state <= w_next;
         if (w_accept) begin
            r_kind <= cmd_kind;
            r_args <= cmd_args;
         end
         if (w_next != r_state) begin
            r_cnt <= '0;
         end else if (r_state == S_LOAD) begin
            r_cnt <= r_cnt + CNT_W'(wr_valid);
         end else if ((r_state == S_MULT) || (r_state == S_READ)) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // Read-valid pipe and registered capture of returned words.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: the valid pipe is reset so an aborted READ cannot emit stale pulses; the data register only for a clean 0.
         r_pipe     <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
      end else begin
         r_pipe[0] <= (r_state == S_READ);
         for (int i = 1; i < READ_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
         end
         r_rd_valid <= r_pipe[READ_LAT-1];
         if (r_pipe[READ_LAT-1]) begin
            r_rd_data <= ctrl_out_data;
         end
      end
   end

   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;

endmodule
